axi_rd_arbiter: RTL

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master (instruction/data) read arbiter onto a single AXI3 AR/R port.
// Optional round-robin arbitration via `define AXI_RD_ARB_ROUND_ROBIN_EN (default: data-first priority).
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-side request / return
  input  logic        inst_rd_req,
  input  logic [2:0]  inst_rd_type,
  input  logic [31:0] inst_rd_addr,
  output logic        inst_rd_rdy,
  output logic        inst_ret_valid,
  output logic        inst_ret_last,
  output logic [31:0] inst_ret_data,
  // data-side request / return
  input  logic        data_rd_req,
  input  logic [2:0]  data_rd_type,
  input  logic [31:0] data_rd_addr,
  output logic        data_rd_rdy,
  output logic        data_ret_valid,
  output logic        data_ret_last,
  output logic [31:0] data_ret_data,
  // AR channel
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [1:0]  m_arlock,
  output logic [3:0]  m_arcache,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  // R channel
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        rresp_err_o
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;

  ar_state_t   state_q, state_d;
  logic        inst_out_q, data_out_q;
  logic        inst_elig, data_elig;
  logic        gnt_inst, gnt_data;
  logic [2:0]  sel_type;
  logic        sel_line;
  logic        inst_hit, data_hit;

`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
  logic        rr_ptr_q;  // 1: inst wins a tie, 0: data wins a tie
`endif

  assign inst_elig = inst_rd_req & ~inst_out_q;
  assign data_elig = data_rd_req & ~data_out_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    case (state_q)
      AR_IDLE: begin
        if (!rst) begin
          if (data_elig && inst_elig) begin
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
            if (rr_ptr_q) gnt_inst = 1'b1;
            else          gnt_data = 1'b1;
`else
            gnt_data = 1'b1;
`endif
          end else if (data_elig) begin
            gnt_data = 1'b1;
          end else if (inst_elig) begin
            gnt_inst = 1'b1;
          end
          if (gnt_inst || gnt_data) state_d = AR_SEND;
        end
      end
      AR_SEND: begin
        // The handshake cycle never grants; the next request is seen back in AR_IDLE.
        if (m_arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  assign sel_type = gnt_data ? data_rd_type : inst_rd_type;
  assign sel_line = (sel_type == 3'b100);

  // A burst ends for a master when its last beat is seen, whether or not it was outstanding.
  assign inst_hit = m_rvalid && (m_rid == INST_ID);
  assign data_hit = m_rvalid && (m_rid == DATA_ID);

  // NOTE: sequential state is updated only with non-blocking assignments so all registers sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= AR_IDLE;
      inst_out_q  <= 1'b0;
      data_out_q  <= 1'b0;
      rresp_err_o <= 1'b0;
      m_arid      <= 4'd0;
      m_araddr    <= 32'd0;
      m_arlen     <= 8'd0;
      m_arsize    <= 3'd0;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (gnt_inst || gnt_data) begin
        m_arid   <= gnt_data ? DATA_ID : INST_ID;
        m_araddr <= gnt_data ? data_rd_addr : inst_rd_addr;
        m_arlen  <= sel_line ? 8'd3 : 8'd0;
        m_arsize <= sel_line ? 3'd2 : {1'b0, sel_type[1:0]};
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
        rr_ptr_q <= gnt_data;
`endif
      end

      if (gnt_inst)                  inst_out_q <= 1'b1;
      else if (inst_hit && m_rlast)  inst_out_q <= 1'b0;

      if (gnt_data)                  data_out_q <= 1'b1;
      else if (data_hit && m_rlast)  data_out_q <= 1'b0;

      if (m_rvalid && (m_rresp != 2'b00)) rresp_err_o <= 1'b1;
    end
  end

  assign inst_rd_rdy = gnt_inst;
  assign data_rd_rdy = gnt_data;
  assign m_arvalid   = (state_q == AR_SEND) && !rst;

  assign m_arburst = 2'b01;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;
  assign m_rready  = 1'b1;

  assign inst_ret_valid = inst_hit;
  assign inst_ret_last  = inst_hit & m_rlast;
  assign inst_ret_data  = m_rdata;
  assign data_ret_valid = data_hit;
  assign data_ret_last  = data_hit & m_rlast;
  assign data_ret_data  = m_rdata;

endmodule
